led_arb: RTL and testbench

- Round-robin arbiter that shares the single rate-limited status LED channel among N requesters (CPU status, UART activity, fault blink, ...).
- Its o_led drives the i_led input of the LED frequency limiter.
- Both blocks are paced by the same clk_div strobe.
- Guarantees each winner a minimum visible slot and a dark gap between owners, so the LED meaning stays distinguishable.

---
 rtl/rr_pick.sv | 30 +++
 rtl/led_arb.sv | 127 ++++++++++++
 tb/tb_led_arb.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rr_pick.sv
// Round-robin winner select: first set request at or after the pointer, wrapping
// N-1 -> 0. Purely combinational so it can be reused by other shared-resource arbiters.
module rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         i_req,
   input  logic [$clog2(N)-1:0] i_ptr,
   output logic                 o_any_c,
   output logic [$clog2(N)-1:0] o_idx_c
);

   localparam int unsigned IW = $clog2(N);

   logic [IW-1:0] w_pos;

   // Walk N positions from the pointer; explicit wrap keeps non-power-of-two N correct.
   always_comb begin
      o_any_c = 1'b0;
      o_idx_c = '0;
      w_pos   = i_ptr;
      for (int unsigned k = 0; k < N; k++) begin
         if (!o_any_c && i_req[w_pos]) begin
            o_any_c = 1'b1;
            o_idx_c = w_pos;
         end
         w_pos = (w_pos == IW'(N - 1)) ? '0 : w_pos + IW'(1);
      end
   end

endmodule

// File: rtl/led_arb.sv
// Round-robin arbiter sharing one rate-limited status LED among N requesters.
// Each owner gets a minimum slot of HOLD strobes, and ownership changes are separated by a dark gap.
module led_arb #(
   parameter int unsigned N    = 4,
   parameter int unsigned HOLD = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_stb,
   input  logic [N-1:0] i_req,
   input  logic [N-1:0] i_led,
   output logic [N-1:0] o_gnt,
   output logic         o_led,
   output logic         o_busy
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = $clog2(HOLD + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [IW-1:0] r_ptr, w_ptr_nxt;
   logic [IW-1:0] r_owner, w_owner_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [N-1:0]  r_gnt, w_gnt_nxt;
   logic          r_led, w_led_nxt;
   logic          r_busy, w_busy_nxt;

   logic          w_any;
   logic [IW-1:0] w_idx;
   logic [N-1:0]  w_owner_mask;
   logic          w_owner_req;
   logic          w_others;
   logic [IW-1:0] w_ptr_inc;

   rr_pick #(.N(N)) u_pick (
      .i_req   (i_req),
      .i_ptr   (r_ptr),
      .o_any_c (w_any),
      .o_idx_c (w_idx)
   );

   assign w_owner_mask = N'(1) << r_owner;
   assign w_owner_req  = |(i_req & w_owner_mask);
   assign w_others     = |(i_req & ~w_owner_mask);
   assign w_ptr_inc    = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);

   // Next-state and registered-output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_gnt_nxt   = r_gnt;
      w_led_nxt   = r_led;
      case (r_state)
         IDLE: begin
            w_gnt_nxt = '0;
            w_led_nxt = 1'b0;
            if (w_any) begin
               w_state_nxt = OWN;
               w_owner_nxt = w_idx;
               w_gnt_nxt   = N'(1) << w_idx;
               w_cnt_nxt   = CW'(HOLD);
               w_led_nxt   = i_led[w_idx];
            end
         end
         OWN: begin
            // Preemption uses the registered count, so a decrement to zero takes effect next cycle.
            if (!w_owner_req || ((r_cnt == '0) && w_others)) begin
               w_state_nxt = GAP;
               w_gnt_nxt   = '0;
               w_led_nxt   = 1'b0;
               w_ptr_nxt   = w_ptr_inc;
            end else begin
               w_led_nxt = i_led[r_owner];
               if (i_stb && (r_cnt != '0)) begin
                  w_cnt_nxt = r_cnt - CW'(1);
               end
            end
         end
         GAP: begin
            w_gnt_nxt = '0;
            w_led_nxt = 1'b0;
            if (i_stb) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_led_nxt   = 1'b0;
         end
      endcase
      w_busy_nxt = (w_state_nxt != IDLE);
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_owner <= '0;
         r_cnt   <= '0;
         r_gnt   <= '0;
         r_led   <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gnt   <= w_gnt_nxt;
         r_led   <= w_led_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign o_gnt  = r_gnt;
   assign o_led  = r_led;
   assign o_busy = r_busy;

endmodule

// File: tb/tb_led_arb.sv
// Scoreboard bench for led_arb: an N=4/HOLD=8 and an N=3/HOLD=2 instance share random stimulus
// and are each compared against a slot/gap reference model.
module tb_led_arb;

   logic       clk;
   logic       rst_n;
   logic       stb;
   logic [3:0] req;
   logic [3:0] led;
   logic [3:0] gnt4;
   logic       led4, busy4;
   logic [2:0] gnt3;
   logic       led3, busy3;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit own;
      bit gap;
      int owner;
      int left;
      int ptr;
   } mstate_t;

   typedef struct packed {
      logic [3:0] gnt;
      logic       led;
      logic       busy;
   } exp_t;

   mstate_t m4, m3;
   exp_t    q4[$];
   exp_t    q3[$];
   exp_t    mx;
   int      order[$];

   led_arb #(.N(4), .HOLD(8)) u_dut4 (
      .i_clk(clk), .i_rst_n(rst_n), .i_stb(stb), .i_req(req), .i_led(led),
      .o_gnt(gnt4), .o_led(led4), .o_busy(busy4)
   );

   led_arb #(.N(3), .HOLD(2)) u_dut3 (
      .i_clk(clk), .i_rst_n(rst_n), .i_stb(stb), .i_req(req[2:0]), .i_led(led[2:0]),
      .o_gnt(gnt3), .o_led(led3), .o_busy(busy3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, want, $time);
      end
   endtask

   // Reference: an owner keeps the LED while it asks, until HOLD strobes have passed and
   // someone else waits; then the LED is dark until a later strobe, and the search restarts after it.
   task automatic model_step(inout mstate_t s, input int n, input int hold, input bit st,
                             input logic [3:0] rq, input logic [3:0] lv, output exp_t e);
      bit others;
      int c;
      e = '0;
      others = 1'b0;
      if (s.gap) begin
         if (st) s.gap = 1'b0;
         e.busy = s.gap;
      end else if (s.own) begin
         for (int k = 0; k < n; k++) if (k != s.owner && rq[k]) others = 1'b1;
         if (!rq[s.owner] || (s.left == 0 && others)) begin
            s.own  = 1'b0;
            s.gap  = 1'b1;
            s.ptr  = (s.owner + 1) % n;
            e.busy = 1'b1;
         end else begin
            e.gnt[s.owner] = 1'b1;
            e.led          = lv[s.owner];
            e.busy         = 1'b1;
            if (st && s.left > 0) s.left = s.left - 1;
         end
      end else begin
         for (int k = 0; k < n; k++) begin
            c = (s.ptr + k) % n;
            if (rq[c] && !s.own) begin
               s.own   = 1'b1;
               s.owner = c;
            end
         end
         if (s.own) begin
            s.left         = hold;
            e.gnt[s.owner] = 1'b1;
            e.led          = lv[s.owner];
            e.busy         = 1'b1;
         end
      end
   endtask

   task automatic step(input bit st, input logic [3:0] rq, input logic [3:0] lv);
      exp_t e;
      stb = st;
      req = rq;
      led = lv;
      @(posedge clk);
      model_step(m4, 4, 8, st, rq, lv, e);
      q4.push_back(e);
      model_step(m3, 3, 2, st, {1'b0, rq[2:0]}, {1'b0, lv[2:0]}, e);
      q3.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      stb   = 1'b0;
      req   = '0;
      led   = '0;
      repeat (3) @(negedge clk);
      chk("rst_gnt4", 32'(gnt4), 32'h0);
      chk("rst_led4", 32'(led4), 32'h0);
      chk("rst_busy4", 32'(busy4), 32'h0);
      chk("rst_gnt3", 32'(gnt3), 32'h0);
      m4 = '{own: 1'b0, gap: 1'b0, owner: 0, left: 0, ptr: 0};
      m3 = '{own: 1'b0, gap: 1'b0, owner: 0, left: 0, ptr: 0};
      q4.delete();
      q3.delete();
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: every cycle both instances present outputs; pop and compare against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         while (q4.size() > 0) begin
            mx = q4.pop_front();
            chk("gnt4", 32'(gnt4), 32'(mx.gnt));
            chk("led4", 32'(led4), 32'(mx.led));
            chk("busy4", 32'(busy4), 32'(mx.busy));
         end
         while (q3.size() > 0) begin
            mx = q3.pop_front();
            chk("gnt3", 32'(gnt3), 32'(mx.gnt));
            chk("led3", 32'(led3), 32'(mx.led));
            chk("busy3", 32'(busy3), 32'(mx.busy));
         end
      end
   end

   initial begin
      logic [3:0] r;
      logic [3:0] prev;
      rst_n = 1'b0;
      stb   = 1'b0;
      req   = '0;
      led   = '0;
      @(negedge clk);
      #1;
      do_reset();

      // Single long-lived requester with a slowly toggling LED level.
      for (int i = 0; i < 170; i++) begin
         r    = 4'($urandom);
         r[2] = ((i / 13) % 2) == 1;
         step((i % 4) == 3, 4'b0100, r);
      end

      // Asynchronous reset while both instances own the LED.
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_gnt4", 32'(gnt4), 32'h0);
      chk("async_led4", 32'(led4), 32'h0);
      chk("async_busy4", 32'(busy4), 32'h0);
      chk("async_gnt3", 32'(gnt3), 32'h0);
      chk("async_busy3", 32'(busy3), 32'h0);
      do_reset();

      // All requesting: grants must rotate.
      prev = '0;
      for (int i = 0; i < 260; i++) begin
         step((i % 4) == 3, 4'b1111, 4'($urandom));
         if (prev == 4'b0000 && gnt4 != 4'b0000) begin
            for (int k = 0; k < 4; k++) if (gnt4[k]) order.push_back(k);
         end
         prev = gnt4;
      end
      chk("rr_count_ok", 32'(order.size() >= 6), 32'h1);
      if (order.size() >= 6) begin
         chk("rr_0", 32'(order[0]), 32'd0);
         chk("rr_1", 32'(order[1]), 32'd1);
         chk("rr_2", 32'(order[2]), 32'd2);
         chk("rr_3", 32'(order[3]), 32'd3);
         chk("rr_4", 32'(order[4]), 32'd0);
         chk("rr_5", 32'(order[5]), 32'd1);
      end

      // Wrap at the top index on the N=3 instance, then two low requesters.
      do_reset();
      for (int i = 0; i < 20; i++) step((i % 4) == 3, 4'b0100, 4'($urandom));
      for (int i = 0; i < 6; i++) step((i % 4) == 3, 4'b0000, 4'($urandom));
      for (int i = 0; i < 60; i++) step((i % 4) == 3, 4'b0011, 4'($urandom));

      // Random requests with sticky bits so slots, preemption and gaps all occur.
      r = 4'($urandom);
      for (int i = 0; i < 2500; i++) begin
         for (int k = 0; k < 4; k++) if ($urandom_range(0, 31) == 0) r[k] = ~r[k];
         step($urandom_range(0, 3) == 0, r, 4'($urandom));
      end
      step(1'b0, 4'b0000, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
